msgpass_rd_addr_gen: RTL and testbench
======================================

Name: msgpass_rd_addr_gen

Overview:
- Read-address generator for the message-pass buffer feeding the memShare VN/SCU datapath.
- Started and stopped by one-cycle control pulses; steps a wrap-around read address once per cycle.
- Holds the address while a decoding-request conflict (DRC) is flagged.
- Drives the buffer's chip-enable and a one-shot start pulse for downstream tick/record logic.

Parameters:
- BUFF_DEPTH, 16, number of buffer words (power of two not required, must be at least 2).
- ADDR_WIDTH, 4, address width; must satisfy 2**ADDR_WIDTH >= BUFF_DEPTH.
- INC_STEP_ALT, 2, alternate increment step (used only with the optional feature).

Ports:
- sys_clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- buffer_read_begin_i  in  1  one-cycle pulse starting a read sweep.
- buffer_read_end_i  in  1  one-cycle pulse ending the sweep.
- is_drc_i  in  1  conflict flag; when high in RUN, the address holds for that cycle.
- addr_o  out  ADDR_WIDTH  buffer read address (raddr_portA).
- cen_o  out  1  buffer chip-enable; high while in RUN.
- start_once_o  out  1  one-cycle pulse in the first RUN cycle.
- busy_o  out  1  equals cen_o; provided for status readers.

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, addr_o=0, cen_o=0, start_once_o=0, busy_o=0.
  - Release is synchronous to the next sys_clk edge.
- States: IDLE, RUN.
- IDLE:
  - addr_o holds 0; cen_o=0.
  - buffer_read_begin_i=1 at edge t: state=RUN, cen_o=1, start_once_o=1 and addr_o=0 all visible after edge t.
  - buffer_read_end_i and is_drc_i are ignored in IDLE.
- RUN, evaluated each edge in this priority order:
  - end=1: state to IDLE, addr_o to 0, cen_o to 0.
  - is_drc_i=1: addr_o holds.
  - Otherwise: addr_o = (addr_o == BUFF_DEPTH-1) ? 0 : addr_o+1.
  - start_once_o is 0 in every RUN cycle after the first.
  - buffer_read_begin_i is ignored in RUN (no restart).
- Simultaneous events:
  - begin and end in the same IDLE cycle: begin is honoured, end is dropped.
  - end and is_drc_i in RUN: end wins.
- Latency: address sequence 0,1,2,… appears on consecutive cycles starting one cycle after the begin pulse. The buffer adds its own read latency and gates on cen_o.
- Wrap-around: the address never exceeds BUFF_DEPTH-1; there is no error or flag on wrap.
- Reset mid-sweep: immediate return to IDLE with all outputs zero. The sweep does not resume.
- All outputs are registered; no combinational input-to-output paths.

Optional Feature:
- Macro: MSGPASS_ADDR_INC_SEL_EN.
- Defined:
  - Adds input incrementSrc_sel_i (1 bit), sampled each RUN cycle.
  - 0: step 1. 1: step INC_STEP_ALT.
  - Wrap uses modulo BUFF_DEPTH: (addr+step) >= BUFF_DEPTH gives addr+step-BUFF_DEPTH.
- Undefined: the port is absent and the step is always 1.

Decomposition:
- Package msgpass_addr_gen_pkg:
  - state enum {IDLE, RUN}.
  - Default BUFF_DEPTH/ADDR_WIDTH constants.
  - INC_STEP_ALT default.
- Sub-module msgpass_wrap_counter:
  - Parameterised modulo counter with clear, hold and step inputs.
  - Instantiated once for addr_o.
- FSM, start pulse and cen logic stay in the top module.

Test Plan:
- Reset: rst=1 mid-clock -> all outputs 0 immediately. Release, then idle 5 cycles -> addr_o stays 0, cen_o=0.
- Basic sweep: begin pulse at cycle 0 -> cycle 1: cen_o=1, start_once_o=1, addr_o=0. Cycles 2..5: addr 1,2,3,4, start_once_o=0. End pulse at addr 4 -> next cycle IDLE, addr_o=0, cen_o=0.
- DRC hold: in RUN at addr 2, is_drc_i=1 for 3 cycles -> addr_o stays 2 for those cycles, then 3,4 resume. End asserted with is_drc_i=1 -> IDLE next cycle.
- Wrap: BUFF_DEPTH=16, run 20 cycles -> addr 0..15 then 0,1,2,3. No pulse on start_once_o at wrap.
- Corner pulses: begin and end together in IDLE -> enters RUN. Begin again in RUN -> no restart, address keeps counting.
- Optional (macro defined): incrementSrc_sel_i=1, INC_STEP_ALT=2, BUFF_DEPTH=5 -> addr 0,2,4,1,3.

Source files
------------

// File: rtl/msgpass_addr_gen_pkg.sv
// Shared types and default sizing for the message-pass buffer read-address generator.
package msgpass_addr_gen_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } rd_state_e;

   localparam int DEF_BUFF_DEPTH   = 16;
   localparam int DEF_ADDR_WIDTH   = 4;
   localparam int DEF_INC_STEP_ALT = 2;

endpackage

// File: rtl/msgpass_wrap_counter.sv
// Modulo-DEPTH counter with clear, hold and a selectable step (1 or STEP_ALT).
// STEP_ALT must be smaller than DEPTH so a single subtraction wraps correctly.
module msgpass_wrap_counter
   import msgpass_addr_gen_pkg::*;
#(
   parameter int DEPTH    = DEF_BUFF_DEPTH,
   parameter int WIDTH    = DEF_ADDR_WIDTH,
   parameter int STEP_ALT = DEF_INC_STEP_ALT
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clear_i,
   input  logic             hold_i,
   input  logic             step_sel_i,
   output logic [WIDTH-1:0] cnt_o
);

   localparam logic [WIDTH:0] DEPTH_W    = (WIDTH+1)'(DEPTH);
   localparam logic [WIDTH:0] STEP_ALT_W = (WIDTH+1)'(STEP_ALT);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;
   logic [WIDTH:0]   step_s;
   logic [WIDTH:0]   sum_s;

   // Next count: one extra sum bit keeps the wrap compare free of overflow.
   always_comb begin
      step_s = (step_sel_i == 1'b1) ? STEP_ALT_W : (WIDTH+1)'(1);
      sum_s  = {1'b0, cnt_q} + step_s;
      if (clear_i == 1'b1) begin
         cnt_d = '0;
      end else if (hold_i == 1'b1) begin
         cnt_d = cnt_q;
      end else if (sum_s >= DEPTH_W) begin
         cnt_d = WIDTH'(sum_s - DEPTH_W);
      end else begin
         cnt_d = WIDTH'(sum_s);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/msgpass_rd_addr_gen.sv
// Read-address generator for the message-pass buffer: begin/end pulses, DRC hold, wrap.
// Optional MSGPASS_ADDR_INC_SEL_EN adds incrementSrc_sel_i to choose step 1 or INC_STEP_ALT.
module msgpass_rd_addr_gen
   import msgpass_addr_gen_pkg::*;
#(
   parameter int BUFF_DEPTH   = DEF_BUFF_DEPTH,
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int INC_STEP_ALT = DEF_INC_STEP_ALT
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic                  buffer_read_begin_i,
   input  logic                  buffer_read_end_i,
   input  logic                  is_drc_i,
`ifdef MSGPASS_ADDR_INC_SEL_EN
   input  logic                  incrementSrc_sel_i,
`endif
   output logic [ADDR_WIDTH-1:0] addr_o,
   output logic                  cen_o,
   output logic                  start_once_o,
   output logic                  busy_o
);

   rd_state_e state_q;
   logic      cen_q;
   logic      start_q;
   logic      cnt_clr_s;
   logic      cnt_hold_s;
   logic      step_sel_s;

`ifdef MSGPASS_ADDR_INC_SEL_EN
   assign step_sel_s = incrementSrc_sel_i;
`else
   assign step_sel_s = 1'b0;
`endif

   // Counter control: cleared outside RUN and on end, end beats a DRC hold.
   always_comb begin
      cnt_clr_s  = 1'b1;
      cnt_hold_s = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_clr_s  = 1'b1;
            cnt_hold_s = 1'b0;
         end
         RUN: begin
            if (buffer_read_end_i == 1'b1) begin
               cnt_clr_s  = 1'b1;
               cnt_hold_s = 1'b0;
            end else if (is_drc_i == 1'b1) begin
               cnt_clr_s  = 1'b0;
               cnt_hold_s = 1'b1;
            end else begin
               cnt_clr_s  = 1'b0;
               cnt_hold_s = 1'b0;
            end
         end
         default: begin
            cnt_clr_s  = 1'b1;
            cnt_hold_s = 1'b0;
         end
      endcase
   end

   // Sweep FSM with registered chip-enable and first-cycle start pulse.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cen_q   <= 1'b0;
         start_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (buffer_read_begin_i == 1'b1) begin
                  state_q <= RUN;
                  cen_q   <= 1'b1;
                  start_q <= 1'b1;
               end else begin
                  state_q <= IDLE;
                  cen_q   <= 1'b0;
                  start_q <= 1'b0;
               end
            end
            RUN: begin
               start_q <= 1'b0;
               if (buffer_read_end_i == 1'b1) begin
                  state_q <= IDLE;
                  cen_q   <= 1'b0;
               end else begin
                  state_q <= RUN;
                  cen_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               cen_q   <= 1'b0;
               start_q <= 1'b0;
            end
         endcase
      end
   end

   msgpass_wrap_counter #(
      .DEPTH    (BUFF_DEPTH),
      .WIDTH    (ADDR_WIDTH),
      .STEP_ALT (INC_STEP_ALT)
   ) u_addr_cnt (
      .clk_i      (sys_clk),
      .rst_i      (rst),
      .clear_i    (cnt_clr_s),
      .hold_i     (cnt_hold_s),
      .step_sel_i (step_sel_s),
      .cnt_o      (addr_o)
   );

   assign cen_o        = cen_q;
   assign busy_o       = cen_q;
   assign start_once_o = start_q;

endmodule

// File: tb/tb_msgpass_rd_addr_gen.sv
// Directed self-checking bench for msgpass_rd_addr_gen (BUFF_DEPTH=16).
// With MSGPASS_ADDR_INC_SEL_EN defined, a second BUFF_DEPTH=5 instance checks the alternate step.
module tb_msgpass_rd_addr_gen;

   logic       sys_clk;
   logic       rst;
   logic       begin_s;
   logic       end_s;
   logic       drc_s;
   logic [3:0] addr_s;
   logic       cen_s;
   logic       start_s;
   logic       busy_s;
   int         checks;
   int         errors;

`ifdef MSGPASS_ADDR_INC_SEL_EN
   logic       sel_s;
   logic [2:0] alt_addr_s;
   logic       alt_cen_s;
   logic       alt_start_s;
   logic       alt_busy_s;
`endif

   msgpass_rd_addr_gen #(
      .BUFF_DEPTH   (16),
      .ADDR_WIDTH   (4),
      .INC_STEP_ALT (2)
   ) dut (
      .sys_clk             (sys_clk),
      .rst                 (rst),
      .buffer_read_begin_i (begin_s),
      .buffer_read_end_i   (end_s),
      .is_drc_i            (drc_s),
`ifdef MSGPASS_ADDR_INC_SEL_EN
      .incrementSrc_sel_i  (1'b0),
`endif
      .addr_o              (addr_s),
      .cen_o               (cen_s),
      .start_once_o        (start_s),
      .busy_o              (busy_s)
   );

`ifdef MSGPASS_ADDR_INC_SEL_EN
   msgpass_rd_addr_gen #(
      .BUFF_DEPTH   (5),
      .ADDR_WIDTH   (3),
      .INC_STEP_ALT (2)
   ) dut_alt (
      .sys_clk             (sys_clk),
      .rst                 (rst),
      .buffer_read_begin_i (begin_s),
      .buffer_read_end_i   (end_s),
      .is_drc_i            (drc_s),
      .incrementSrc_sel_i  (sel_s),
      .addr_o              (alt_addr_s),
      .cen_o               (alt_cen_s),
      .start_once_o        (alt_start_s),
      .busy_o              (alt_busy_s)
   );
`endif

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [31:0] a, input logic c, input logic s);
      check_val({tag, ".addr"}, 32'(addr_s), a);
      check_val({tag, ".cen"}, 32'(cen_s), 32'(c));
      check_val({tag, ".start"}, 32'(start_s), 32'(s));
      check_val({tag, ".busy"}, 32'(busy_s), 32'(c));
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst     = 1'b1;
      begin_s = 1'b0;
      end_s   = 1'b0;
      drc_s   = 1'b0;
`ifdef MSGPASS_ADDR_INC_SEL_EN
      sel_s   = 1'b0;
`endif
      #1;
      check_outs("reset", 32'd0, 1'b0, 1'b0);
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_outs("idle", 32'd0, 1'b0, 1'b0);
      end

      // end and drc are ignored in IDLE
      end_s = 1'b1;
      drc_s = 1'b1;
      tick();
      end_s = 1'b0;
      drc_s = 1'b0;
      check_outs("idle_ign", 32'd0, 1'b0, 1'b0);

      // basic sweep
      begin_s = 1'b1;
      tick();
      begin_s = 1'b0;
      check_outs("sweep_first", 32'd0, 1'b1, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check_outs("sweep", 32'(i), 1'b1, 1'b0);
      end
      end_s = 1'b1;
      tick();
      end_s = 1'b0;
      check_outs("sweep_end", 32'd0, 1'b0, 1'b0);

      // DRC hold, then end together with DRC
      begin_s = 1'b1;
      tick();
      begin_s = 1'b0;
      check_outs("drc_first", 32'd0, 1'b1, 1'b1);
      tick();
      tick();
      check_outs("drc_pre", 32'd2, 1'b1, 1'b0);
      drc_s = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_outs("drc_hold", 32'd2, 1'b1, 1'b0);
      end
      drc_s = 1'b0;
      tick();
      check_outs("drc_resume3", 32'd3, 1'b1, 1'b0);
      tick();
      check_outs("drc_resume4", 32'd4, 1'b1, 1'b0);
      end_s = 1'b1;
      drc_s = 1'b1;
      tick();
      end_s = 1'b0;
      drc_s = 1'b0;
      check_outs("drc_end", 32'd0, 1'b0, 1'b0);

      // wrap over 20 cycles
      begin_s = 1'b1;
      tick();
      begin_s = 1'b0;
      check_outs("wrap_first", 32'd0, 1'b1, 1'b1);
      for (int i = 1; i < 20; i++) begin
         tick();
         check_outs("wrap", 32'(i % 16), 1'b1, 1'b0);
      end
      end_s = 1'b1;
      tick();
      end_s = 1'b0;
      check_outs("wrap_end", 32'd0, 1'b0, 1'b0);

      // begin and end together in IDLE, then begin again in RUN
      begin_s = 1'b1;
      end_s   = 1'b1;
      tick();
      begin_s = 1'b0;
      end_s   = 1'b0;
      check_outs("both_first", 32'd0, 1'b1, 1'b1);
      tick();
      check_outs("both_cnt", 32'd1, 1'b1, 1'b0);
      begin_s = 1'b1;
      tick();
      begin_s = 1'b0;
      check_outs("no_restart", 32'd2, 1'b1, 1'b0);
      tick();
      check_outs("no_restart2", 32'd3, 1'b1, 1'b0);

      // asynchronous reset mid-sweep
      #3;
      rst = 1'b1;
      #1;
      check_outs("rst_mid", 32'd0, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      tick();
      tick();
      check_outs("rst_no_resume", 32'd0, 1'b0, 1'b0);

`ifdef MSGPASS_ADDR_INC_SEL_EN
      // alternate step 2 on BUFF_DEPTH 5: 0,2,4,1,3
      sel_s   = 1'b1;
      begin_s = 1'b1;
      tick();
      begin_s = 1'b0;
      check_val("alt_0", 32'(alt_addr_s), 32'd0);
      check_val("alt_start", 32'(alt_start_s), 32'd1);
      tick();
      check_val("alt_2", 32'(alt_addr_s), 32'd2);
      tick();
      check_val("alt_4", 32'(alt_addr_s), 32'd4);
      tick();
      check_val("alt_1", 32'(alt_addr_s), 32'd1);
      tick();
      check_val("alt_3", 32'(alt_addr_s), 32'd3);
      check_val("alt_cen", 32'(alt_cen_s), 32'd1);
      check_val("alt_busy", 32'(alt_busy_s), 32'd1);
      end_s = 1'b1;
      tick();
      end_s = 1'b0;
      sel_s = 1'b0;
      check_val("alt_end", 32'(alt_addr_s), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
